// File: rtl/fft16_out_reorder.sv
// fft16_out_reorder: captures a bit-reversed 16-point FFT output stream into a
// two-bank ping-pong buffer and replays each frame in natural bin order under
// a valid/ready handshake. Frames arriving with no free bank are dropped (ovf).
module fft16_out_reorder #(
  parameter int N   = 8,
  parameter int PTS = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic [N-1:0] y_r,
  input  logic [N-1:0] y_im,
  input  logic         in_valid,
  input  logic         in_first,
  output logic [N-1:0] out_r,
  output logic [N-1:0] out_im,
  output logic [3:0]   out_idx,
  output logic         out_valid,
  output logic         out_last,
  input  logic         out_ready,
  output logic         ovf
);

  localparam int AW = 4;
  localparam logic [AW-1:0] LAST = AW'(PTS - 1);

  typedef enum logic {W_IDLE, W_FILL} wstate_t;
  typedef enum logic {R_IDLE, R_SEND} rstate_t;

  wstate_t wstate, wstate_n;
  rstate_t rstate, rstate_n;

  logic [N-1:0]  mem_r  [2][PTS];
  logic [N-1:0]  mem_im [2][PTS];

  logic [1:0]    full;
  logic          wbank, rbank;
  logic [AW-1:0] wcnt, wcnt_n;

  logic          wr_en, fill_done, ovf_n;
  logic [AW-1:0] wr_addr;

  logic          hs, ld, ld_bank, rd_done, vld_clr, free_now;
  logic [AW-1:0] ld_idx;

  function automatic logic [AW-1:0] bitrev4(input logic [AW-1:0] b);
    return {b[0], b[1], b[2], b[3]};
  endfunction

  // The bin-15 handshake frees the read bank on the same edge a new frame may claim it.
  assign free_now = rd_done && (rbank == wbank);
  assign out_last = out_valid && (out_idx == LAST);

  // Write FSM: next state, write strobe/address, frame completion and drop pulse.
  always_comb begin
    wr_en     = 1'b0;
    wr_addr   = '0;
    wcnt_n    = wcnt;
    wstate_n  = wstate;
    fill_done = 1'b0;
    ovf_n     = 1'b0;
    unique case (wstate)
      W_IDLE: begin
        if (in_valid && in_first) begin
          if (!full[wbank] || free_now) begin
            wr_en    = 1'b1;
            wcnt_n   = AW'(1);
            wstate_n = W_FILL;
          end else begin
            ovf_n = 1'b1;
          end
        end
      end
      W_FILL: begin
        if (in_valid) begin
          wr_en = 1'b1;
          if (in_first) begin
            wcnt_n = AW'(1);
          end else begin
            wr_addr = bitrev4(wcnt);
            if (wcnt == LAST) begin
              fill_done = 1'b1;
              wcnt_n    = '0;
              wstate_n  = W_IDLE;
            end else begin
              wcnt_n = wcnt + AW'(1);
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Read FSM: next state and which bank/bin to load into the output registers.
  always_comb begin
    hs       = out_valid && out_ready;
    ld       = 1'b0;
    ld_bank  = rbank;
    ld_idx   = '0;
    rd_done  = 1'b0;
    vld_clr  = 1'b0;
    rstate_n = rstate;
    unique case (rstate)
      R_IDLE: begin
        if (full[rbank]) begin
          ld       = 1'b1;
          rstate_n = R_SEND;
        end
      end
      R_SEND: begin
        if (hs) begin
          if (out_idx != LAST) begin
            ld     = 1'b1;
            ld_idx = out_idx + AW'(1);
          end else begin
            rd_done = 1'b1;
            if (full[~rbank]) begin
              ld      = 1'b1;
              ld_bank = ~rbank;
            end else begin
              vld_clr  = 1'b1;
              rstate_n = R_IDLE;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Sample storage; contents are meaningless unless the bank's full flag is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wbank][wr_addr]  <= y_r;
      mem_im[wbank][wr_addr] <= y_im;
    end
  end

  // Control state, bank bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      wstate    <= W_IDLE;
      rstate    <= R_IDLE;
      wcnt      <= '0;
      wbank     <= 1'b0;
      rbank     <= 1'b0;
      full      <= '0;
      ovf       <= 1'b0;
      out_r     <= '0;
      out_im    <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
    end else begin
      wstate <= wstate_n;
      rstate <= rstate_n;
      wcnt   <= wcnt_n;
      ovf    <= ovf_n;
      if (fill_done) begin
        full[wbank] <= 1'b1;
        wbank       <= ~wbank;
      end
      if (rd_done) begin
        full[rbank] <= 1'b0;
        rbank       <= ~rbank;
      end
      if (ld) begin
        out_r     <= mem_r[ld_bank][ld_idx];
        out_im    <= mem_im[ld_bank][ld_idx];
        out_idx   <= ld_idx;
        out_valid <= 1'b1;
      end else if (vld_clr) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fft16_out_reorder.md
Name: fft16_out_reorder

Overview:
- Receive side of the 16-point FFT output stream. Captures the serial y_r/y_im samples, which the FFT emits in bit-reversed order, one per valid cycle.
- Stores each frame in a ping-pong buffer and replays it in natural order X[0]..X[15] to downstream logic under a valid/ready handshake.
- Sits directly after fft_16point. Decouples FFT frame timing from consumer back-pressure.

Parameters:
- N, 8, sample width per real/imag component (two's complement, passed through unmodified)
- PTS, 16, points per frame (fixed at 16; index width 4)

Ports:
- clk  input  1  system clock, rising edge
- clear  input  1  asynchronous active-low reset
- y_r  input  N  FFT output, real part
- y_im  input  N  FFT output, imaginary part
- in_valid  input  1  y_r/y_im valid this cycle
- in_first  input  1  marks sample 0 of a frame; qualified by in_valid
- out_r  output  N  reordered real sample
- out_im  output  N  reordered imaginary sample
- out_idx  output  4  natural bin index of out_r/out_im
- out_valid  output  1  output sample valid
- out_last  output  1  high with bin 15
- out_ready  input  1  consumer accepts when out_valid & out_ready
- ovf  output  1  one-cycle pulse: frame dropped, no free bank

Behaviour:
- Reset: clock and reset are one clock `clk`; reset `clear` is asynchronous, active-low. While clear=0:
  - out_r, out_im, out_idx = 0; out_valid, out_last, ovf = 0.
  - Both banks empty; write bank = 0, read bank = 0.
  - Write FSM = W_IDLE; read FSM = R_IDLE; counters = 0.
  - Reset mid-frame discards all buffered data.
- Storage: 2 banks x 16 entries x 2N bits, registers.
- Write FSM, W_IDLE:
  - On in_valid & in_first with the write bank empty (or being freed this same cycle), store the sample at addr 0, set wcnt=1, go to W_FILL.
  - If both banks are full, pulse ovf, stay in W_IDLE, ignore samples until the next in_first.
- Write FSM, W_FILL:
  - Each in_valid stores the sample at addr = bitrev4(wcnt), then wcnt++.
  - Gaps in in_valid are allowed; wcnt holds.
  - in_valid & in_first mid-frame restarts the frame: the sample goes to addr 0, wcnt=1, the partial frame is discarded.
  - When the sample with wcnt=15 is stored: mark the bank full, toggle the write bank, go to W_IDLE.
  - A new in_first may arrive on the very next cycle and is then handled per W_IDLE.
- Read FSM, R_IDLE: when the read bank is full, load bin 0 into the output registers on the next edge, set out_valid=1, out_idx=0, go to R_SEND.
- Read FSM, R_SEND:
  - out_r/out_im/out_idx hold stable while out_valid & !out_ready.
  - On handshake at bin i<15, present bin i+1 on the next edge (zero-bubble streaming).
  - out_last = (out_idx==15) & out_valid.
  - On handshake of bin 15: mark the bank empty, toggle the read bank.
  - If the other bank is already full, present its bin 0 on the next edge (no idle cycle); otherwise out_valid=0 and go to R_IDLE.
- Latency: the 16th input sample is stored at edge E; bin 0 is valid after edge E+1. With out_ready held high, the frame drains in 16 consecutive cycles.
- Simultaneous events: a bank freed (bin-15 handshake) and in_first targeting that bank in the same cycle are both accepted, with no ovf. A write into one bank and a read of the other in the same cycle never conflict.
- Write and read never address the same bank concurrently.
- ovf is never asserted while a free bank exists.
- Data path: no arithmetic; samples pass bit-exact.
- bitrev4(b3 b2 b1 b0) = b0 b1 b2 b3.

Test Plan:
- Single frame, continuous:
  - Stimulus: in_first at k=0, y_r=k, y_im=-k for k=0..15; out_ready=1.
  - Response: out_idx 0..15 carrying y_r = 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 with matching negated y_im. out_valid first high 2 edges after the last input. out_last only at idx 15.
- Back-pressure:
  - Stimulus: same frame; toggle out_ready 1,0,0,1,…
  - Response: no sample lost or duplicated. Outputs hold stable while not ready. Sequence identical to the first test.
- Back-to-back frames:
  - Stimulus: 3 frames with no gap (y_r = 0x10+k, 0x20+k, 0x30+k); out_ready=1.
  - Response: three reordered frames; after the first, output streams with no bubbles; ovf never asserted.
- Overflow:
  - Stimulus: out_ready=0; send 3 frames.
  - Response: ovf pulses once, at frame 3's in_first. Then raise out_ready: frames 1 and 2 only are output, in order.
- Restart mid-frame:
  - Stimulus: in_first, 7 samples, then in_first plus 16 samples 0xA0+k.
  - Response: only the second frame is emitted, bin i = 0xA0+bitrev4(i).
- Reset mid-drain:
  - Stimulus: clear=0 at out_idx=5.
  - Response: all outputs 0 asynchronously. After release, no output until a new full frame arrives.
